jtag_scan_master: RTL and testbench

//  Synthesizable JTAG host that loads fir_top over its tms/tdi/tdo port. From one start pulse it

---
 rtl/jtag_scan_master.sv | 235 +++++++++++++++++++++++
 tb/tb_jtag_scan_master.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_scan_master.sv
// JTAG host: one start pulse drives a full IR scan followed by a full DR scan on tck/tms/tdi, capturing tdo.
// Optional `JTAG_TLR_RESET_EN prefixes every transaction with a 6-step Test-Logic-Reset walk.
module jtag_scan_master #(
    parameter int IR_W     = 4,
    parameter int DR_W     = 48,
    parameter int HALF_DIV = 1
) (
    input  logic            w_clk,
    input  logic            w_rstn,
    input  logic            start,
    input  logic [IR_W-1:0] ir_code,
    input  logic [DR_W-1:0] dr_data,
    input  logic            tdo,
    output logic            tck,
    output logic            tms,
    output logic            tdi,
    output logic            busy,
    output logic            done,
    output logic [DR_W-1:0] dr_capture
);

    localparam int MAX_W = (IR_W > DR_W) ? IR_W : DR_W;
    localparam int BIT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam int DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [BIT_W-1:0] IR_LAST  = BIT_W'(IR_W - 1);
    localparam logic [BIT_W-1:0] DR_LAST  = BIT_W'(DR_W - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);

    typedef enum logic [2:0] {
        IDLE, TLR, IR_HDR, IR_SHIFT, IR_TAIL, DR_HDR, DR_SHIFT, DR_TAIL
    } state_t;

`ifdef JTAG_TLR_RESET_EN
    localparam state_t FIRST_ST = TLR;
`else
    localparam state_t FIRST_ST = IR_HDR;
`endif

    state_t            state_q, state_d;
    logic [2:0]        step_q, step_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              phase_q, phase_d;
    logic              tck_q, tck_d;
    logic              tms_q, tms_d;
    logic              tdi_q, tdi_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DR_W-1:0]   cap_q, cap_d;
    logic [IR_W-1:0]   ir_sh_q, ir_sh_d;
    logic [DR_W-1:0]   dr_sh_q, dr_sh_d;
    logic              last_bit_d;

    // tms value for a given step of a given state; step counts from 0 inside header/tail states
    function automatic logic step_tms(input state_t st, input logic [2:0] step, input logic last_bit);
        logic v;
        v = 1'b0;
        case (st)
            TLR:                      v = (step != 3'd5);
            IR_HDR:                   v = (step < 3'd2);
            IR_SHIFT, DR_SHIFT:       v = last_bit;
            IR_TAIL, DR_HDR, DR_TAIL: v = (step == 3'd0);
            default:                  v = 1'b0;
        endcase
        return v;
    endfunction

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        bit_d      = bit_q;
        div_d      = div_q;
        phase_d    = phase_q;
        tck_d      = tck_q;
        tms_d      = tms_q;
        tdi_d      = tdi_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cap_d      = cap_q;
        ir_sh_d    = ir_sh_q;
        dr_sh_d    = dr_sh_q;
        last_bit_d = 1'b0;

        if (state_q == IDLE) begin
            tck_d = 1'b0;
            // a start coinciding with the done pulse is deliberately dropped
            if (start && !done_q) begin
                state_d = FIRST_ST;
                step_d  = '0;
                bit_d   = '0;
                div_d   = '0;
                phase_d = 1'b0;
                ir_sh_d = ir_code;
                dr_sh_d = dr_data;
                cap_d   = '0;
                busy_d  = 1'b1;
                tms_d   = 1'b1;
                tdi_d   = 1'b0;
            end
        end else if (div_q != DIV_LAST) begin
            div_d = div_q + 1'b1;
        end else begin
            div_d = '0;
            if (!phase_q) begin
                phase_d = 1'b1;
                tck_d   = 1'b1;
                if (state_q == DR_SHIFT) begin
                    cap_d = {cap_q[DR_W-2:0], tdo};
                end
            end else begin
                phase_d = 1'b0;
                tck_d   = 1'b0;
                step_d  = step_q + 3'd1;
                case (state_q)
                    TLR: begin
                        if (step_q == 3'd5) begin
                            state_d = IR_HDR;
                            step_d  = '0;
                        end
                    end
                    IR_HDR: begin
                        if (step_q == 3'd3) begin
                            state_d = IR_SHIFT;
                            step_d  = '0;
                            bit_d   = '0;
                        end
                    end
                    IR_SHIFT: begin
                        step_d = '0;
                        if (bit_q == IR_LAST) begin
                            state_d = IR_TAIL;
                        end else begin
                            bit_d   = bit_q + 1'b1;
                            ir_sh_d = ir_sh_q << 1;
                        end
                    end
                    IR_TAIL: begin
                        if (step_q == 3'd1) begin
                            state_d = DR_HDR;
                            step_d  = '0;
                        end
                    end
                    DR_HDR: begin
                        if (step_q == 3'd2) begin
                            state_d = DR_SHIFT;
                            step_d  = '0;
                            bit_d   = '0;
                        end
                    end
                    DR_SHIFT: begin
                        step_d = '0;
                        if (bit_q == DR_LAST) begin
                            state_d = DR_TAIL;
                        end else begin
                            bit_d   = bit_q + 1'b1;
                            dr_sh_d = dr_sh_q << 1;
                        end
                    end
                    DR_TAIL: begin
                        if (step_q == 3'd1) begin
                            state_d = IDLE;
                            step_d  = '0;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        step_d  = '0;
                    end
                endcase

                // outputs for the step that begins on this falling edge
                if (state_d == IDLE) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    tms_d  = 1'b0;
                    tdi_d  = 1'b0;
                    bit_d  = '0;
                end else begin
                    last_bit_d = ((state_d == IR_SHIFT) && (bit_d == IR_LAST)) ||
                                 ((state_d == DR_SHIFT) && (bit_d == DR_LAST));
                    tms_d = step_tms(state_d, step_d, last_bit_d);
                    if (state_d == IR_SHIFT) begin
                        tdi_d = ir_sh_d[IR_W-1];
                    end else if (state_d == DR_SHIFT) begin
                        tdi_d = dr_sh_d[DR_W-1];
                    end else begin
                        tdi_d = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge w_clk) begin
        if (!w_rstn) begin
            state_q <= IDLE;
            step_q  <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            phase_q <= 1'b0;
            tck_q   <= 1'b0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cap_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            phase_q <= phase_d;
            tck_q   <= tck_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cap_q   <= cap_d;
        end
    end

    // shift data is only meaningful while busy, so it carries no reset
    always_ff @(posedge w_clk) begin
        ir_sh_q <= ir_sh_d;
        dr_sh_q <= dr_sh_d;
    end

    assign tck        = tck_q;
    assign tms        = tms_q;
    assign tdi        = tdi_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign dr_capture = cap_q;

endmodule

// File: tb/tb_jtag_scan_master.sv
// Self-checking bench for jtag_scan_master: two instances (HALF_DIV=1 and 3) against a step-list reference model.
module tb_jtag_scan_master;

    localparam int IR_W = 4;
    localparam int DR_W = 48;
`ifdef JTAG_TLR_RESET_EN
    localparam int TLR_STEPS = 6;
`else
    localparam int TLR_STEPS = 0;
`endif
    localparam int SHIFT_DR0 = TLR_STEPS + 4 + IR_W + 2 + 3;

    logic w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    logic            w_rstn;
    logic            start_b;
    logic            sel;
    logic            tdo_b;
    logic [IR_W-1:0] ir_b;
    logic [DR_W-1:0] dr_b;

    logic            start_1, tck_1, tms_1, tdi_1, busy_1, done_1;
    logic [DR_W-1:0] cap_1;
    logic            start_3, tck_3, tms_3, tdi_3, busy_3, done_3;
    logic [DR_W-1:0] cap_3;

    assign start_1 = start_b & ~sel;
    assign start_3 = start_b & sel;

    jtag_scan_master #(.IR_W(IR_W), .DR_W(DR_W), .HALF_DIV(1)) u_dut1 (
        .w_clk(w_clk), .w_rstn(w_rstn), .start(start_1), .ir_code(ir_b), .dr_data(dr_b),
        .tdo(tdo_b), .tck(tck_1), .tms(tms_1), .tdi(tdi_1), .busy(busy_1), .done(done_1),
        .dr_capture(cap_1)
    );

    jtag_scan_master #(.IR_W(IR_W), .DR_W(DR_W), .HALF_DIV(3)) u_dut3 (
        .w_clk(w_clk), .w_rstn(w_rstn), .start(start_3), .ir_code(ir_b), .dr_data(dr_b),
        .tdo(tdo_b), .tck(tck_3), .tms(tms_3), .tdi(tdi_3), .busy(busy_3), .done(done_3),
        .dr_capture(cap_3)
    );

    logic            m_tck, m_tms, m_tdi, m_busy, m_done;
    logic [DR_W-1:0] m_cap;
    assign m_tck  = sel ? tck_3  : tck_1;
    assign m_tms  = sel ? tms_3  : tms_1;
    assign m_tdi  = sel ? tdi_3  : tdi_1;
    assign m_busy = sel ? busy_3 : busy_1;
    assign m_done = sel ? done_3 : done_1;
    assign m_cap  = sel ? cap_3  : cap_1;

    int checks   = 0;
    int failures = 0;

    // reference: one entry per tck period, listing tms, tdi and which DR bit (or -1) is shifted
    logic exp_tms[$];
    logic exp_tdi[$];
    int   exp_idx[$];

    task automatic push_step(input logic t, input logic d, input int idx);
        exp_tms.push_back(t);
        exp_tdi.push_back(d);
        exp_idx.push_back(idx);
    endtask

    task automatic build_model(input logic [IR_W-1:0] ir, input logic [DR_W-1:0] dr);
        logic [IR_W-1:0] ir_t;
        logic [DR_W-1:0] dr_t;
        exp_tms.delete();
        exp_tdi.delete();
        exp_idx.delete();
        for (int i = 0; i < TLR_STEPS; i++) push_step(i < 5, 1'b0, -1);
        push_step(1'b1, 1'b0, -1);
        push_step(1'b1, 1'b0, -1);
        push_step(1'b0, 1'b0, -1);
        push_step(1'b0, 1'b0, -1);
        for (int i = 0; i < IR_W; i++) begin
            ir_t = ir >> (IR_W - 1 - i);
            push_step(i == IR_W - 1, ir_t[0], -1);
        end
        push_step(1'b1, 1'b0, -1);
        push_step(1'b0, 1'b0, -1);
        push_step(1'b1, 1'b0, -1);
        push_step(1'b0, 1'b0, -1);
        push_step(1'b0, 1'b0, -1);
        for (int i = 0; i < DR_W; i++) begin
            dr_t = dr >> (DR_W - 1 - i);
            push_step(i == DR_W - 1, dr_t[0], i);
        end
        push_step(1'b1, 1'b0, -1);
        push_step(1'b0, 1'b0, -1);
    endtask

    // Runs one transaction on the selected instance and compares every cycle against the model.
    // poke: cycle index at which a stray start (with altered data) is injected; -1 for none.
    task automatic run_txn(input int hd, input logic [IR_W-1:0] ir, input logic [DR_W-1:0] dr,
                           input logic [DR_W-1:0] tap, input int poke, input bit at_done,
                           input string name);
        int              n, total, s, bi;
        bit              bad;
        logic [4:0]      obs, expv;
        logic [DR_W-1:0] tap_t;
        build_model(ir, dr);
        n     = exp_tms.size();
        total = n * 2 * hd;
        bad   = 1'b0;
        @(negedge w_clk);
        ir_b    = ir;
        dr_b    = dr;
        start_b = 1'b1;
        @(posedge w_clk);
        for (int i = 0; i <= total; i++) begin
            @(negedge w_clk);
            if (i == 0) start_b = 1'b0;
            if (i == poke) begin
                start_b = 1'b1;
                dr_b    = '0;
                ir_b    = ~ir;
            end else if (i == poke + 1) begin
                start_b = 1'b0;
            end
            if (i < total) begin
                s = i / (2 * hd);
                expv = {((i % (2 * hd)) >= hd), exp_tms[s], exp_tdi[s], 1'b1, 1'b0};
                if (exp_idx[s] >= 0) begin
                    bi    = DR_W - 1 - exp_idx[s];
                    tap_t = tap >> bi;
                    tdo_b = tap_t[0];
                end else begin
                    tdo_b = 1'($urandom);
                end
            end else begin
                s    = n;
                expv = 5'b00001;
            end
            obs = {m_tck, m_tms, m_tdi, m_busy, m_done};
            if (!bad) begin
                checks++;
                if (obs !== expv) begin
                    failures++;
                    bad = 1'b1;
                    $display("FAIL %s_stream cyc=%0d step=%0d tck_tms_tdi_busy_done=%b required=%b",
                             name, i, s, obs, expv);
                end
            end
        end
        checks++;
        if (m_cap !== tap) begin
            failures++;
            $display("FAIL %s_capture got=%h required=%h", name, m_cap, tap);
        end
        if (at_done) begin
            start_b = 1'b1;
            @(negedge w_clk);
            start_b = 1'b0;
            checks++;
            if (m_busy !== 1'b0 || m_done !== 1'b0) begin
                failures++;
                $display("FAIL %s_start_at_done busy=%b done=%b required busy=0 done=0",
                         name, m_busy, m_done);
            end
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge w_clk);
            obs = {m_tck, m_tms, m_tdi, m_busy, m_done};
            checks++;
            if (obs !== 5'b00000 || m_cap !== tap) begin
                failures++;
                $display("FAIL %s_idle k=%0d tck_tms_tdi_busy_done=%b cap=%h required=00000 cap=%h",
                         name, k, obs, m_cap, tap);
            end
        end
    endtask

    function automatic logic [DR_W-1:0] rand_dr();
        return {16'($urandom), 32'($urandom)};
    endfunction

    task automatic test_reset();
        w_rstn  = 1'b0;
        start_b = 1'b0;
        sel     = 1'b0;
        repeat (3) @(negedge w_clk);
        checks++;
        if ({tck_1, tms_1, tdi_1, busy_1, done_1} !== 5'b01000 || cap_1 !== '0) begin
            failures++;
            $display("FAIL reset_div1 tck_tms_tdi_busy_done=%b cap=%h required=01000 cap=0",
                     {tck_1, tms_1, tdi_1, busy_1, done_1}, cap_1);
        end
        checks++;
        if ({tck_3, tms_3, tdi_3, busy_3, done_3} !== 5'b01000 || cap_3 !== '0) begin
            failures++;
            $display("FAIL reset_div3 tck_tms_tdi_busy_done=%b cap=%h required=01000 cap=0",
                     {tck_3, tms_3, tdi_3, busy_3, done_3}, cap_3);
        end
        w_rstn = 1'b1;
        @(negedge w_clk);
    endtask

    task automatic test_t1_vectors();
        run_txn(1, 4'b1010, 48'h8312_D6EE_FAED, rand_dr(), -1, 1'b0, "t1");
    endtask

    task automatic test_tap_capture();
        run_txn(1, 4'($urandom), rand_dr(), 48'h0123_4567_89AB, -1, 1'b0, "tap_capture");
    endtask

    task automatic test_start_while_busy();
        run_txn(1, 4'($urandom), rand_dr(), rand_dr(), (SHIFT_DR0 + 10) * 2 + 1, 1'b0, "start_busy");
    endtask

    task automatic test_start_at_done();
        run_txn(1, 4'($urandom), rand_dr(), rand_dr(), -1, 1'b1, "start_at_done");
    endtask

    task automatic test_back_to_back();
        run_txn(1, 4'($urandom), rand_dr(), rand_dr(), -1, 1'b0, "b2b_a");
        run_txn(1, 4'($urandom), rand_dr(), rand_dr(), -1, 1'b0, "b2b_b");
    endtask

    task automatic test_reset_mid_scan();
        int target;
        target = (SHIFT_DR0 + 20) * 2 + 1;
        @(negedge w_clk);
        ir_b    = 4'($urandom);
        dr_b    = rand_dr();
        start_b = 1'b1;
        @(posedge w_clk);
        for (int i = 0; i <= target; i++) begin
            @(negedge w_clk);
            if (i == 0) start_b = 1'b0;
            tdo_b = 1'b1;
        end
        w_rstn = 1'b0;
        @(negedge w_clk);
        w_rstn = 1'b1;
        checks++;
        if ({m_tck, m_tms, m_tdi, m_busy, m_done} !== 5'b01000 || m_cap !== '0) begin
            failures++;
            $display("FAIL reset_mid tck_tms_tdi_busy_done=%b cap=%h required=01000 cap=0",
                     {m_tck, m_tms, m_tdi, m_busy, m_done}, m_cap);
        end
        run_txn(1, 4'($urandom), rand_dr(), rand_dr(), -1, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            run_txn(1, 4'($urandom), rand_dr(), rand_dr(), -1, 1'b0, "random");
        end
    endtask

    task automatic test_half_div3();
        @(negedge w_clk);
        sel = 1'b1;
        run_txn(3, 4'b1010, 48'h8312_D6EE_FAED, 48'h0123_4567_89AB, -1, 1'b0, "div3_a");
        run_txn(3, 4'($urandom), rand_dr(), rand_dr(), -1, 1'b0, "div3_b");
        @(negedge w_clk);
        sel = 1'b0;
    endtask

    initial begin
        w_rstn  = 1'b0;
        start_b = 1'b0;
        sel     = 1'b0;
        tdo_b   = 1'b0;
        ir_b    = '0;
        dr_b    = '0;
        test_reset();
        test_t1_vectors();
        test_tap_capture();
        test_start_while_busy();
        test_start_at_done();
        test_back_to_back();
        test_reset_mid_scan();
        test_random();
        test_half_div3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
